mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 43 ++++
 rtl/mem_lane_fmt.sv | 49 ++++
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory access controller: FSM states, access sizes, default timeout.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_access_ctrl_pkg;

  // Number of REQ cycles spent waiting for Mem_Ack before the access is abandoned
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BSEL_WORD     = 2'b00,
    BSEL_HALF     = 2'b01,
    BSEL_BYTE     = 2'b10,
    BSEL_WORD_ALT = 2'b11
  } bytesel_t;

  // The spare encoding behaves exactly like a word access
  function automatic bytesel_t norm_size(input logic [1:0] sel);
    bytesel_t s;
    s = bytesel_t'(sel);
    if (s == BSEL_WORD_ALT) begin
      s = BSEL_WORD;
    end
    return s;
  endfunction

  // Words need a 4-byte boundary, halfwords a 2-byte boundary, bytes never fault
  function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] addr_lo);
    logic mis;
    case (norm_size(sel))
      BSEL_HALF: mis = addr_lo[0];
      BSEL_BYTE: mis = 1'b0;
      default:   mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store byte enables and data replication, load lane extract and extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  req_sel,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_rep,
  input  logic [1:0]  rsp_sel,
  input  logic [1:0]  rsp_addr_lo,
  input  logic        rsp_sext,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_data
);

  logic [31:0] rsp_shifted;

  // Request side: pick the enabled lanes and copy the right-aligned store data into every lane
  always_comb begin
    req_be        = 4'b1111;
    req_wdata_rep = req_wdata;
    case (norm_size(req_sel))
      BSEL_HALF: begin
        req_be        = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      BSEL_BYTE: begin
        req_be        = 4'b0001 << req_addr_lo;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Response side: move the addressed little-endian lane to bit 0, then sign- or zero-extend
  always_comb begin
    rsp_shifted = rsp_rdata >> {rsp_addr_lo, 3'b000};
    rsp_data    = rsp_rdata;
    case (norm_size(rsp_sel))
      BSEL_HALF: rsp_data = {{16{rsp_sext & rsp_shifted[15]}}, rsp_shifted[15:0]};
      BSEL_BYTE: rsp_data = {{24{rsp_sext & rsp_shifted[7]}}, rsp_shifted[7:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Pipeline-to-memory access controller: one load/store at a time with ack timeout.
// Latency: 3 cycles minimum (IDLE, REQ with same-cycle ack, DONE); up to TIMEOUT+2.
// Backpressure: Stall_Out freezes the pipeline from request until the DONE cycle.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [1:0]  ByteSel_In,
  input  logic [1:0]  L16B_In,
  input  logic [31:0] Addr_In,
  input  logic [31:0] WriteData_In,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [3:0]  Mem_BE,
  output logic [31:0] Mem_WData,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData,
  output logic        Stall_Out,
  output logic [31:0] ReadData_Out,
  output logic        Valid_Out,
  output logic        Error_Out
);

  // Last REQ cycle index before the access is abandoned
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q  = ST_IDLE;
  state_t      state_d;
  logic [7:0]  cnt_q    = '0;
  logic        we_q     = 1'b0;
  logic [31:0] addr_q   = '0;
  logic [3:0]  be_q     = '0;
  logic [31:0] wdata_q  = '0;
  logic [1:0]  sel_q    = '0;
  logic [1:0]  lo_q     = '0;
  logic        sext_q   = 1'b0;
  logic        to_q     = 1'b0;
  logic [31:0] rdata_q  = '0;

  logic        access;
  logic        misaligned;
  logic        start;
  logic        timeout_hit;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_rdata;
  logic        unused_l16b_hi;

  assign access         = MemRead_In | MemWrite_In;
  assign misaligned     = is_misaligned(ByteSel_In, Addr_In[1:0]);
  assign start          = access & ~misaligned;
  assign timeout_hit    = (cnt_q == CNT_LAST);
  assign unused_l16b_hi = L16B_In[1];

  mem_lane_fmt u_lane_fmt (
    .req_sel       (ByteSel_In),
    .req_addr_lo   (Addr_In[1:0]),
    .req_wdata     (WriteData_In),
    .req_be        (fmt_be),
    .req_wdata_rep (fmt_wdata),
    .rsp_sel       (sel_q),
    .rsp_addr_lo   (lo_q),
    .rsp_sext      (sext_q),
    .rsp_rdata     (Mem_RData),
    .rsp_data      (fmt_rdata)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ack wins over timeout on the final REQ cycle; DONE always falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ:  if (Mem_Ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; Mem_Req is left alone during Reset so it drops on the edge
  always_comb begin
    Mem_Req   = 1'b0;
    Stall_Out = 1'b0;
    Valid_Out = 1'b0;
    Error_Out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        Stall_Out = start;
        Error_Out = access & misaligned;
      end
      ST_REQ: begin
        Mem_Req   = 1'b1;
        Stall_Out = 1'b1;
      end
      ST_DONE: begin
        Valid_Out = 1'b1;
        Error_Out = to_q;
      end
      default: ;
    endcase
    if (Reset) begin
      Stall_Out = 1'b0;
      Valid_Out = 1'b0;
      Error_Out = 1'b0;
    end
  end

  // Wait counter: runs only while staying in REQ, so it restarts at 0 for every access
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_REQ && state_d == ST_REQ) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Request capture on IDLE->REQ keeps the bus stable; response capture on ack or timeout
  always_ff @(posedge Clock) begin
    if (Reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      lo_q    <= '0;
      sext_q  <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      to_q <= (state_q == ST_REQ) && !Mem_Ack && timeout_hit;
      if (state_q == ST_IDLE && start) begin
        we_q    <= MemWrite_In;
        addr_q  <= {Addr_In[31:2], 2'b00};
        be_q    <= fmt_be;
        wdata_q <= fmt_wdata;
        sel_q   <= ByteSel_In;
        lo_q    <= Addr_In[1:0];
        sext_q  <= L16B_In[0];
      end
      if (state_q == ST_REQ) begin
        if (Mem_Ack) begin
          if (!we_q) begin
            rdata_q <= fmt_rdata;
          end
        end else if (timeout_hit) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign Mem_We       = we_q;
  assign Mem_Addr     = addr_q;
  assign Mem_BE       = be_q;
  assign Mem_WData    = wdata_q;
  assign ReadData_Out = rdata_q;

endmodule
